replay_buffer_fsm: RTL and testbench
====================================

REPLAY_BUFFER_FSM -- requirements
Module: replay_buffer_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port busy_n, input, 1 bit: downstream busy, active low.
REQ-004 SHALL have port we_i, input, 1 bit: write request that starts a packet store.
REQ-005 SHALL have port to_i, input, 1 bit: replay timeout event.
REQ-006 SHALL have port acknak_i, input, 2 bits: 01 = ACK, 10 = NAK, 00 and 11 = none.
REQ-007 SHALL have port rdy_i, input, 1 bit: ready from the buffer.
REQ-008 SHALL have port seq, input, 12 bits: current sequence base.
REQ-009 SHALL have port num_to_rep, input, 12 bits: replay end sequence.
REQ-010 SHALL have outputs rst, we_o, to_o, rdy_o, busy_n_o and rep, 1 bit each; acknak_o, 2 bits; crc_num, 4 bits; count, 12 bits: buffer control, all registered.

Function
REQ-011 SHALL implement states S0, S1, S2, S2W, S3, S4, S5, S4RA and S4RB.
- S0 = reset.
- S1 = idle.
- S2 and S2W = write loop.
- S3 = ACK forward.
- S4 and S5 = NAK/timeout setup.
- S4RA and S4RB = replay loop.
REQ-012 SHALL leave S0 for S1 on the first clock edge at which reset is low; rst = 1 only in S0.
REQ-013 SHALL clear count to 0 on every clock edge while in S1.
REQ-014 SHALL select the next state from S1 by this priority:
- we_i = 1 -> S2.
- else acknak_i = 10 -> S4.
- else to_i = 1 -> S4.
- else acknak_i = 01 -> S3.
- else stay in S1.
REQ-015 SHALL drive, in S2, we_o = 1 and crc_num = count[3:0], then go to S2W unconditionally.
REQ-016 SHALL increment count by 1 in S2W, then go to S1 if the new count equals 10, else go to S2 (one packet = 10 words, crc_num values 0 through 9).
REQ-017 SHALL drive acknak_o = 01 for exactly one cycle in S3 and return to S1.
REQ-018 SHALL, in S4:
- drive acknak_o = 10 on a NAK entry, or to_o = 1 on a timeout entry;
- latch count_to = num_to_rep - seq, modulo 4096;
- stay in S4 until busy_n = 0, then go to S5.
REQ-019 SHALL forward busy_n to busy_n_o while in S4 and S5; busy_n_o = 1 in all other states.
REQ-020 SHALL stay in S5 while busy_n = 0, and on busy_n = 1 go to S4RA, or to S1 if count_to = 0.
REQ-021 SHALL, in S4RA, drive rep = 1 and count = internal replay counter, with the counter cleared to 0 on entry from S5; then go to S4RB.
REQ-022 SHALL, in S4RB:
- drive rep = 0;
- increment the replay counter;
- go to S1 when the new counter equals count_to, else go to S4RA.
REQ-023 SHALL produce exactly count_to rep pulses per replay, one every 2 cycles, with count values 0 through count_to-1.
REQ-024 SHALL register rdy_i to rdy_o with 1-cycle latency in all states.
REQ-025 SHALL hold crc_num at its last value outside S2; acknak_o = 00 and to_o = 0 outside S3 and S4.
REQ-026 SHALL ignore we_i, acknak_i and to_i outside S1; events are not queued.

Reset
REQ-027 SHALL, while reset is high, on each clock edge:
- enter S0;
- set rst = 1, count = 0, crc_num = 0, acknak_o = 00;
- set we_o, to_o, rep and rdy_o to 0, busy_n_o = 1;
- clear count_to and the replay counter.
REQ-028 SHALL abort any write or replay in progress when reset is asserted mid-operation, with no further we_o or rep pulses until S1 is re-entered.

Configuration
REQ-029 SHALL, when macro FSM_BUSY_TIMEOUT_EN is defined:
- count consecutive cycles spent in S4 or S5;
- force a return to S1 after 255 cycles without leaving those states;
- emit no rep pulse in that case.
Without the macro, S4 and S5 wait indefinitely.

Verification
REQ-030 SHALL cover reset high for 2 cycles then low: rst = 1 then 0, S1 reached on the first edge, all outputs at their reset values.
REQ-031 SHALL cover a write: we_i pulse in S1 -> 10 we_o pulses with crc_num 0..9, count reaching 10, return to S1, count cleared to 0.
REQ-032 SHALL cover an ACK: acknak_i = 01 for one cycle in S1 -> acknak_o = 01 for exactly one cycle, then 00.
REQ-033 SHALL cover a NAK replay:
- stimulus: acknak_i = 10, seq = 0, num_to_rep = 39, busy_n low one cycle then high;
- response: busy_n_o follows busy_n; 39 rep pulses with count 0..38; then S1.
REQ-034 SHALL cover boundary cases:
- NAK with num_to_rep = seq -> no rep pulse, return to S1;
- we_i and NAK asserted together -> write taken;
- reset asserted mid-replay -> no further rep pulses.

Source files
------------

// File: rtl/replay_buffer_fsm.sv
// Replay buffer controller: packet write loop, ACK forward, NAK/timeout replay loop.
// Define FSM_BUSY_TIMEOUT_EN to bound the busy wait in S4/S5 to 255 cycles.
module replay_buffer_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic        busy_n,
    input  logic        we_i,
    input  logic        to_i,
    input  logic [1:0]  acknak_i,
    input  logic        rdy_i,
    input  logic [11:0] seq,
    input  logic [11:0] num_to_rep,
    output logic        rst,
    output logic        we_o,
    output logic        to_o,
    output logic        rdy_o,
    output logic        busy_n_o,
    output logic        rep,
    output logic [1:0]  acknak_o,
    output logic [3:0]  crc_num,
    output logic [11:0] count
);

    typedef enum logic [3:0] {S0, S1, S2, S2W, S3, S4, S5, S4RA, S4RB} state_t;

    state_t      state_q, state_d;
    logic [11:0] count_q, count_d;
    logic [11:0] count_to_q, count_to_d;
    logic [11:0] rep_cnt_q, rep_cnt_d;
    logic [3:0]  crc_q, crc_d;
    logic        nak_q, nak_d;
    logic        rst_q, we_q, we_d, to_q, to_d, rep_q, rep_d, bn_q, bn_d, rdy_q;
    logic [1:0]  ak_q, ak_d;
`ifdef FSM_BUSY_TIMEOUT_EN
    logic [7:0]  wait_q, wait_d;
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        count_to_d = count_to_q;
        rep_cnt_d  = rep_cnt_q;
        crc_d      = crc_q;
        nak_d      = nak_q;
        case (state_q)
            S0: state_d = S1;
            S1: begin
                count_d = '0;
                if (we_i) begin
                    state_d = S2;
                end else if (acknak_i == 2'b10) begin
                    state_d    = S4;
                    nak_d      = 1'b1;
                    count_to_d = num_to_rep - seq;
                end else if (to_i) begin
                    state_d    = S4;
                    nak_d      = 1'b0;
                    count_to_d = num_to_rep - seq;
                end else if (acknak_i == 2'b01) begin
                    state_d = S3;
                end
            end
            S2:  state_d = S2W;
            S2W: begin
                count_d = count_q + 12'd1;
                state_d = (count_q + 12'd1 == 12'd10) ? S1 : S2;
            end
            S3: state_d = S1;
            S4: if (!busy_n) state_d = S5;
            S5: begin
                if (busy_n) begin
                    if (count_to_q == '0) begin
                        state_d = S1;
                    end else begin
                        state_d   = S4RA;
                        rep_cnt_d = '0;
                        count_d   = '0;
                    end
                end
            end
            S4RA: state_d = S4RB;
            S4RB: begin
                rep_cnt_d = rep_cnt_q + 12'd1;
                if (rep_cnt_q + 12'd1 == count_to_q) begin
                    state_d = S1;
                end else begin
                    state_d = S4RA;
                    count_d = rep_cnt_q + 12'd1;
                end
            end
            default: state_d = S0;
        endcase
`ifdef FSM_BUSY_TIMEOUT_EN
        wait_d = '0;
        if (state_q == S4 || state_q == S5) begin
            wait_d = wait_q + 8'd1;
            if (wait_q == 8'd254) state_d = S1;
        end
`endif
        // Outputs are decoded from the next state so they line up with the state register.
        we_d = (state_d == S2);
        if (state_d == S2) crc_d = count_d[3:0];
        rep_d = (state_d == S4RA);
        ak_d  = (state_d == S3) ? 2'b01 : ((state_d == S4 && nak_d) ? 2'b10 : 2'b00);
        to_d  = (state_d == S4) && !nak_d;
        bn_d  = (state_d == S4 || state_d == S5) ? busy_n : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S0;
            count_q    <= '0;
            count_to_q <= '0;
            rep_cnt_q  <= '0;
            crc_q      <= '0;
            nak_q      <= 1'b0;
            rst_q      <= 1'b1;
            we_q       <= 1'b0;
            to_q       <= 1'b0;
            rep_q      <= 1'b0;
            bn_q       <= 1'b1;
            ak_q       <= '0;
            rdy_q      <= 1'b0;
`ifdef FSM_BUSY_TIMEOUT_EN
            wait_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            count_to_q <= count_to_d;
            rep_cnt_q  <= rep_cnt_d;
            crc_q      <= crc_d;
            nak_q      <= nak_d;
            rst_q      <= (state_d == S0);
            we_q       <= we_d;
            to_q       <= to_d;
            rep_q      <= rep_d;
            bn_q       <= bn_d;
            ak_q       <= ak_d;
            rdy_q      <= rdy_i;
`ifdef FSM_BUSY_TIMEOUT_EN
            wait_q     <= wait_d;
`endif
        end
    end

    assign rst      = rst_q;
    assign we_o     = we_q;
    assign to_o     = to_q;
    assign rdy_o    = rdy_q;
    assign busy_n_o = bn_q;
    assign rep      = rep_q;
    assign acknak_o = ak_q;
    assign crc_num  = crc_q;
    assign count    = count_q;

endmodule

// File: tb/tb_replay_buffer_fsm.sv
// Randomized transaction-level bench for replay_buffer_fsm; each transaction expands to a per-cycle expected trace.
module tb_replay_buffer_fsm;

    logic        clk = 1'b0;
    logic        reset, busy_n, we_i, to_i, rdy_i;
    logic [1:0]  acknak_i;
    logic [11:0] seq, num_to_rep;
    logic        rst, we_o, to_o, rdy_o, busy_n_o, rep;
    logic [1:0]  acknak_o;
    logic [3:0]  crc_num;
    logic [11:0] count;

    always #5 clk = ~clk;

    replay_buffer_fsm dut (
        .clk(clk), .reset(reset), .busy_n(busy_n), .we_i(we_i), .to_i(to_i),
        .acknak_i(acknak_i), .rdy_i(rdy_i), .seq(seq), .num_to_rep(num_to_rep),
        .rst(rst), .we_o(we_o), .to_o(to_o), .rdy_o(rdy_o), .busy_n_o(busy_n_o),
        .rep(rep), .acknak_o(acknak_o), .crc_num(crc_num), .count(count)
    );

    typedef struct {
        logic       rs, we, to, bn;
        logic [1:0] ak;
        logic       e_rst, e_we, e_to, e_rep, e_bn;
        logic [1:0] e_ak;
        logic [3:0] e_crc;
        logic [11:0] e_cnt;
    } cyc_t;

    cyc_t        plan[$];
    logic [3:0]  m_crc = '0;
    logic [11:0] m_cnt = '0;
    int total = 0, bad = 0, cyc = 0, rep_seen = 0, we_seen = 0;

    task automatic chk(string nm, logic [11:0] act, logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [11:0] model_ct(int s, int n);
        return 12'((((n - s) % 4096) + 4096) % 4096);
    endfunction

    // Junk control inputs: anything outside idle must be ignored by the DUT.
    function automatic cyc_t base();
        cyc_t c;
        c.rs = 1'b0; c.we = 1'($urandom); c.to = 1'($urandom);
        c.ak = 2'($urandom); c.bn = 1'($urandom);
        c.e_rst = 1'b0; c.e_we = 1'b0; c.e_to = 1'b0; c.e_rep = 1'b0; c.e_bn = 1'b1;
        c.e_ak = 2'b00; c.e_crc = m_crc; c.e_cnt = m_cnt;
        return c;
    endfunction

    task automatic plan_reset(int n);
        cyc_t c;
        m_crc = '0; m_cnt = '0;
        for (int i = 0; i < n; i++) begin
            c = base(); c.rs = 1'b1; c.e_rst = 1'b1; plan.push_back(c);
        end
        c = base(); plan.push_back(c);
    endtask

    task automatic plan_idle(int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            m_cnt = '0;
            c = base(); c.we = 1'b0; c.to = 1'b0;
            c.ak = 1'($urandom) ? 2'b11 : 2'b00;
            plan.push_back(c);
        end
    endtask

    task automatic plan_write(bit with_nak);
        cyc_t c;
        for (int k = 0; k < 10; k++) begin
            m_crc = 4'(k); m_cnt = 12'(k);
            c = base();
            if (k == 0) begin
                c.we = 1'b1;
                if (with_nak) c.ak = 2'b10;
            end
            c.e_we = 1'b1; plan.push_back(c);
            c = base(); plan.push_back(c);
        end
        m_cnt = 12'd10;
        c = base(); plan.push_back(c);
    endtask

    task automatic plan_ack();
        cyc_t c;
        m_cnt = '0;
        c = base(); c.we = 1'b0; c.to = 1'b0; c.ak = 2'b01; c.e_ak = 2'b01;
        plan.push_back(c);
        c = base(); plan.push_back(c);
    endtask

    task automatic plan_nak(bit is_nak, int s, int n, int w, int l);
        cyc_t c;
        int ct;
        logic [1:0] eak;
        seq = 12'(s); num_to_rep = 12'(n);
        ct = int'(model_ct(s, n));
        eak = is_nak ? 2'b10 : 2'b00;
        m_cnt = '0;
        c = base(); c.we = 1'b0;
        if (is_nak) c.ak = 2'b10;
        else begin c.to = 1'b1; c.ak = {1'b0, 1'($urandom)}; end
        c.e_ak = eak; c.e_to = !is_nak; c.e_bn = c.bn; plan.push_back(c);
        for (int i = 0; i < w; i++) begin
            c = base(); c.bn = 1'b1; c.e_ak = eak; c.e_to = !is_nak; plan.push_back(c);
        end
        for (int i = 0; i < l; i++) begin
            c = base(); c.bn = 1'b0; c.e_bn = 1'b0; plan.push_back(c);
        end
        c = base(); c.bn = 1'b1;
        if (ct == 0) begin
            plan.push_back(c);
        end else begin
            c.e_rep = 1'b1; plan.push_back(c);
            for (int i = 0; i < ct; i++) begin
                c = base(); plan.push_back(c);
                if (i + 1 < ct) begin
                    m_cnt = 12'(i + 1);
                    c = base(); c.e_rep = 1'b1; plan.push_back(c);
                end else begin
                    c = base(); plan.push_back(c);
                end
            end
        end
    endtask

    task automatic play(int limit);
        cyc_t c;
        logic er;
        int n = 0;
        while (plan.size() > 0 && n < limit) begin
            c = plan.pop_front();
            reset = c.rs; we_i = c.we; to_i = c.to; acknak_i = c.ak; busy_n = c.bn;
            rdy_i = 1'($urandom);
            er = c.rs ? 1'b0 : rdy_i;
            @(posedge clk);
            #1;
            chk("rst",      12'(rst),      12'(c.e_rst));
            chk("we_o",     12'(we_o),     12'(c.e_we));
            chk("to_o",     12'(to_o),     12'(c.e_to));
            chk("rep",      12'(rep),      12'(c.e_rep));
            chk("busy_n_o", 12'(busy_n_o), 12'(c.e_bn));
            chk("acknak_o", 12'(acknak_o), 12'(c.e_ak));
            chk("crc_num",  12'(crc_num),  12'(c.e_crc));
            chk("count",    count,         c.e_cnt);
            chk("rdy_o",    12'(rdy_o),    12'(er));
            if (rep === 1'b1) rep_seen++;
            if (we_o === 1'b1) we_seen++;
            cyc++; n++;
        end
        plan.delete();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; busy_n = 1'b1; we_i = 1'b0; to_i = 1'b0; rdy_i = 1'b0;
        acknak_i = 2'b00; seq = '0; num_to_rep = '0;

        plan_reset(2); plan_idle(2); play(1000);

        we_seen = 0; plan_write(1'b0); plan_idle(2); play(1000);
        chk("write_pulses", 12'(we_seen), 12'd10);

        plan_ack(); plan_idle(1); play(1000);

        rep_seen = 0; plan_nak(1'b1, 0, 39, 0, 1); plan_idle(1); play(1000);
        chk("nak39_pulses", 12'(rep_seen), 12'd39);

        rep_seen = 0; plan_nak(1'b1, 100, 100, 2, 3); plan_idle(1); play(1000);
        chk("nak_zero_pulses", 12'(rep_seen), 12'd0);

        we_seen = 0; plan_write(1'b1); plan_idle(1); play(1000);
        chk("we_nak_pulses", 12'(we_seen), 12'd10);

        rep_seen = 0; plan_nak(1'b0, 4090, 5, 1, 2); plan_idle(1); play(1000);
        chk("to_wrap_pulses", 12'(rep_seen), 12'd11);

        rep_seen = 0; plan_nak(1'b1, 0, 20, 0, 1); play(15);
        plan_reset(2); plan_idle(30); play(1000);
        chk("abort_pulses", 12'(rep_seen), 12'd7);

        we_seen = 0; plan_write(1'b0); play(7);
        plan_reset(1); plan_idle(20); play(1000);
        chk("abort_we_pulses", 12'(we_seen), 12'd4);

        for (int t = 0; t < 60; t++) begin
            int kind;
            kind = int'($urandom_range(3, 0));
            plan_idle(int'($urandom_range(3, 0)));
            case (kind)
                0: plan_write(1'($urandom));
                1: plan_ack();
                default: begin
                    int s;
                    s = int'($urandom_range(4095, 0));
                    plan_nak(kind == 2, s, s + int'($urandom_range(12, 0)),
                             int'($urandom_range(4, 0)), int'($urandom_range(4, 1)));
                end
            endcase
            plan_idle(1);
            play(1000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
